// File: rtl/seg7_pkg.sv
// Shared glyph table and FSM state type for the seven-segment hex reader.
// Glyphs are a-first: bit 6 = segment a ... bit 0 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-seven-segment decoder.
// Any pattern outside the 16 glyphs (blank included) flags err with hex forced to 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       err
);

    // Glyph lookup
    always_comb begin
        hex = 4'h0;
        err = 1'b0;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: begin
                hex = 4'h0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_hex_reader.sv
// Recovers hex digits from a sampled seven-segment bus: sync, debounce, decode, valid/ready out.
// Optional SEG7_DP_EN adds the decimal point to the compared pattern and the output.
module seg7_hex_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DROP_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
`ifdef SEG7_DP_EN
    input  logic              seg_dp,
    output logic              out_dp,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_hex,
    output logic              out_err,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef SEG7_DP_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif
    localparam logic [7:0]        STABLE_L = 8'(STABLE_CYCLES);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [PW-1:0] seg_raw_s;
    logic [PW-1:0] sync1_r, s_seg_r, last_seg_r, cand_r;
    logic [PW-1:0] cand_next_s, last_seg_next_s;
    logic [7:0]    cnt_r, cnt_next_s;
    state_t        state_r, state_next_s;
    logic          new_event_s, fire_s, load_s, drop_s;
    logic [3:0]    dec_hex_s;
    logic          dec_err_s;

`ifdef SEG7_DP_EN
    assign seg_raw_s = {seg_dp, seg_in};
`else
    assign seg_raw_s = seg_in;
`endif

    // Two-flop synchronizer; nothing downstream looks at seg_in directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            s_seg_r <= '0;
        end else begin
            sync1_r <= seg_raw_s;
            s_seg_r <= sync1_r;
        end
    end

    // Stability FSM; acceptance is judged on the edge where cnt reaches STABLE_CYCLES
    always_comb begin
        state_next_s    = state_r;
        cand_next_s     = cand_r;
        cnt_next_s      = cnt_r;
        last_seg_next_s = last_seg_r;
        new_event_s     = 1'b0;
        case (state_r)
            IDLE, HOLD: begin
                if (s_seg_r != last_seg_r) begin
                    state_next_s = SETTLE;
                    cand_next_s  = s_seg_r;
                    cnt_next_s   = 8'd1;
                end else begin
                    state_next_s = state_r;
                end
            end
            SETTLE: begin
                if (s_seg_r == cand_r) begin
                    cnt_next_s = cnt_r + 8'd1;
                end else begin
                    cand_next_s = s_seg_r;
                    cnt_next_s  = 8'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
        // A re-settle onto the already reported pattern updates nothing visible
        if ((state_next_s == SETTLE) && (cnt_next_s == STABLE_L)) begin
            last_seg_next_s = cand_next_s;
            cnt_next_s      = 8'd0;
            if (cand_next_s[6:0] == SEG_BLANK) begin
                state_next_s = IDLE;
            end else begin
                state_next_s = HOLD;
                new_event_s  = (cand_next_s != last_seg_r);
            end
        end else begin
            new_event_s = 1'b0;
        end
    end

    // FSM state, candidate, counter and last accepted pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cand_r     <= '0;
            cnt_r      <= 8'd0;
            last_seg_r <= '0;
        end else begin
            state_r    <= state_next_s;
            cand_r     <= cand_next_s;
            cnt_r      <= cnt_next_s;
            last_seg_r <= last_seg_next_s;
        end
    end

    seg7_pattern_decode u_decode (
        .seg (cand_next_s[6:0]),
        .hex (dec_hex_s),
        .err (dec_err_s)
    );

    assign fire_s = out_valid && out_ready;
    assign load_s = new_event_s && (!out_valid || fire_s);
    assign drop_s = new_event_s && out_valid && !fire_s;

    // Single-entry output register with saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_hex   <= 4'h0;
            out_err   <= 1'b0;
            drop_cnt  <= '0;
`ifdef SEG7_DP_EN
            out_dp    <= 1'b0;
`endif
        end else begin
            if (load_s) begin
                out_valid <= 1'b1;
                out_hex   <= dec_hex_s;
                out_err   <= dec_err_s;
`ifdef SEG7_DP_EN
                out_dp    <= cand_next_s[7];
`endif
            end else if (fire_s) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
            if (drop_s && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Self-checking bench for seg7_hex_reader: directed scenarios plus random patterns
// checked every cycle against a run-length reference model.
module tb_seg7_hex_reader;

    localparam int STABLE = 4;
    localparam int DW     = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          out_ready;
    logic [6:0]    seg_in;
    logic          out_valid;
    logic [3:0]    out_hex;
    logic          out_err;
    logic [DW-1:0] drop_cnt;
`ifdef SEG7_DP_EN
    logic          seg_dp = 1'b0;
    logic          out_dp;
`endif

    seg7_hex_reader #(.STABLE_CYCLES(STABLE), .DROP_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
`ifdef SEG7_DP_EN
        .seg_dp    (seg_dp),
        .out_dp    (out_dp),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hex   (out_hex),
        .out_err   (out_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [6:0] m_sync1, m_sseg, m_last, m_run_val;
    int         m_run_len;
    logic       m_valid, m_err;
    logic [3:0] m_hex;
    int         m_drop;
    logic [4:0] acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync1   = 7'h00;
        m_sseg    = 7'h00;
        m_last    = 7'h00;
        m_run_val = 7'h00;
        m_run_len = 1000;
        m_valid   = 1'b0;
        m_hex     = 4'h0;
        m_err     = 1'b0;
        m_drop    = 0;
    endtask

    task automatic model_decode(input logic [6:0] p, output logic [3:0] h, output logic e);
        h = 4'h0;
        e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == p) begin
                h = 4'(k);
                e = 1'b0;
            end
        end
    endtask

    // One clock edge: a pattern is accepted when its run of identical samples reaches STABLE
    task automatic model_edge();
        logic ev, fire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ev = 1'b0;
        if (m_sseg == m_run_val) begin
            if (m_run_len < 1000) m_run_len++;
        end else begin
            m_run_val = m_sseg;
            m_run_len = 1;
        end
        if (m_run_len == STABLE) begin
            ev     = (m_run_val != 7'h00) && (m_run_val != m_last);
            m_last = m_run_val;
        end
        fire = m_valid && out_ready;
        if (ev) begin
            if (!m_valid || fire) begin
                model_decode(m_run_val, m_hex, m_err);
                m_valid = 1'b1;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (fire) begin
            m_valid = 1'b0;
        end
        m_sseg  = m_sync1;
        m_sync1 = seg_in;
    endtask

    task automatic tick();
        logic       pre_fire;
        logic [4:0] pre_data;
        pre_fire = (out_valid === 1'b1) && (out_ready === 1'b1);
        pre_data = {out_err, out_hex};
        @(posedge clk);
        model_edge();
        if (pre_fire && rst_n) acc_q.push_back(pre_data);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_hex",   32'(out_hex),   32'(m_hex));
        chk("out_err",   32'(out_err),   32'(m_err));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) tick();
    endtask

    initial begin
        int first, nv;
        rst_n     = 1'b0;
        seg_in    = 7'h00;
        out_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        hold(7'h00, 6);

        // single glyph 6D: valid rises 6 cycles after the change, for one cycle
        acc_q.delete();
        seg_in = 7'h6D;
        first  = -1;
        nv     = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        chk("s1_latency", 32'(first), 32'd6);
        chk("s1_valid_cycles", 32'(nv), 32'd1);
        chk("s1_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("s1_data", 32'(acc_q[0]), 32'h02);

        // all 16 glyphs in order
        acc_q.delete();
        for (int g = 0; g < 16; g++) hold(glyph[g], 10);
        hold(glyph[15], 2);
        chk("walk_events", 32'(acc_q.size()), 32'd16);
        for (int i = 0; i < acc_q.size(); i++) chk("walk_data", 32'(acc_q[i]), 32'(i));
        chk("walk_drops", 32'(drop_cnt), 32'd0);

        // glitching 7F never settles; return to 3D is not a new event
        acc_q.delete();
        hold(7'h3D, 10);
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 7'h7F : 7'h3D, 2);
        hold(7'h3D, 12);
        chk("glitch_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("glitch_data", 32'(acc_q[0]), 32'h0D);

        // illegal pattern
        acc_q.delete();
        hold(7'h55, 10);
        chk("illegal_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("illegal_data", 32'(acc_q[0]), 32'h10);

        // backpressure: first event held, next two dropped
        acc_q.delete();
        out_ready = 1'b0;
        hold(7'h30, 8);
        hold(7'h79, 8);
        hold(7'h33, 8);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_hex", 32'(out_hex), 32'h1);
        chk("bp_drops", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        hold(7'h33, 4);
        chk("bp_events", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("bp_data", 32'(acc_q[0]), 32'h01);

        // blank between identical glyphs re-arms reporting
        acc_q.delete();
        hold(7'h5B, 10);
        hold(7'h00, 10);
        hold(7'h5B, 10);
        chk("blank_events", 32'(acc_q.size()), 32'd2);
        for (int i = 0; i < acc_q.size(); i++) chk("blank_data", 32'(acc_q[i]), 32'h05);

        // reset while settling discards everything
        acc_q.delete();
        hold(7'h7E, 3);
        rst_n  = 1'b0;
        seg_in = 7'h00;
        model_reset();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        hold(7'h00, 12);
        chk("rst_events", 32'(acc_q.size()), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_drops", 32'(drop_cnt), 32'd0);

        // random patterns, hold lengths and backpressure
        for (int s = 0; s < 80; s++) begin
            int         kind, len;
            logic [6:0] p;
            kind = int'($urandom_range(0, 3));
            if (kind < 2)       p = glyph[$urandom_range(0, 15)];
            else if (kind == 2) p = 7'($urandom);
            else                p = 7'h00;
            len    = int'($urandom_range(1, 10));
            seg_in = p;
            for (int c = 0; c < len; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_hex_reader.md
# seg7_hex_reader

Recovers hex digits from a driven seven-segment pattern, the inverse of the per-segment hex decoders. Synchronizes the external pattern, requires it to be stable for a programmable number of cycles, maps it back to a 4-bit value, and presents each new digit on a valid/ready output. Sits between a sampled display bus and the verification/monitor logic that checks what the decoders actually drove.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted; legal range 1..255.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  raw segments {a,b,c,d,e,f,g}; seg_in[6]=a; active-high; asynchronous to clk.
- out_valid  output  1  digit available.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_hex  output  4  recovered digit; 0 when out_err=1.
- out_err  output  1  accepted pattern is not one of the 16 legal glyphs.
- drop_cnt  output  DROP_W  events lost because the output was full; saturates at all-ones.

## Operation
- Two-flop synchronizer on seg_in produces s_seg; all further logic uses s_seg only.
- Legal glyphs, a-first hex: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47. Any other nonzero pattern is illegal. 00 means blank.
- FSM:
  - IDLE: waiting for a change. Exits to SETTLE when s_seg != last_seg; loads cnt=1.
  - SETTLE: s_seg == cand increments cnt. s_seg != cand reloads cand and sets cnt=1.
  - SETTLE accepts when cnt reaches STABLE_CYCLES:
    - blank pattern: no event; go to IDLE.
    - nonblank pattern: generate one event; go to HOLD.
    - In both cases last_seg is updated.
  - HOLD: stable, already reported. Any s_seg != last_seg goes to SETTLE. Re-stabilizing on the same pattern after a glitch produces no new event.
- Event handling:
  - Output empty: load out_hex/out_err and set out_valid.
  - Output full and not handshaking this cycle: drop the event; drop_cnt+1, saturating.
  - out_valid && out_ready in the same cycle as a new event: the new event loads (no drop).
- out_valid stays high and its data stays stable until accepted.
- Reset values: out_valid=0, out_hex=0, out_err=0, drop_cnt=0, FSM=IDLE, last_seg=00, synchronizer=00, cnt=0.
- Reset asserted mid-settle or with out_valid high discards everything; no event on release.

## Timing
- A seg_in change stable from cycle t appears on s_seg at t+2.
- out_valid rises at cycle t+2+STABLE_CYCLES, i.e. on the edge where cnt reaches STABLE_CYCLES.
- STABLE_CYCLES=1: event on the first cycle s_seg shows the new value.
- Throughput: at most one event per STABLE_CYCLES cycles. The output register supports back-to-back accepts.
- out_ready is not used combinationally toward any output other than the drop/load decision. No combinational path from seg_in to outputs.

## Configuration
- SEG7_DP_EN defined:
  - adds seg_dp input (1 bit), synchronized alongside seg_in and part of the stability compare and last_seg;
  - adds out_dp output carrying the accepted dp bit;
  - a dp-only change is a new pattern and produces an event.
  - Blank means all seven segments off, regardless of dp.
- SEG7_DP_EN undefined: ports absent; behaviour as above on 7 bits.

## Structure
- Package seg7_pkg: the 16 glyph constants, SEG_BLANK, state enum {IDLE, SETTLE, HOLD}.
- Sub-module seg7_pattern_decode: combinational 7-bit to {hex, err} lookup. The reader instantiates it on cand.

## Test plan
- Reset, then hold seg_in=6D steady with STABLE_CYCLES=4, out_ready=1: exactly one event, out_hex=2, out_err=0, out_valid high one cycle at t+6.
- Step through all 16 glyphs, each held 10 cycles: 16 events, out_hex=0..F in order, drop_cnt=0.
- seg_in=3D, then seg_in=7F toggled every 2 cycles for 12 cycles, then back to 3D: one event D only, no event during the toggling, none for the return to 3D.
- Illegal 55 held: event with out_err=1, out_hex=0.
- out_ready=0 with glyphs 30, 79, 33 each held 8 cycles: out_valid holds hex 1, drop_cnt=2. Then raise out_ready: hex 1 accepted once.
- Pattern 5B held, then 00 held, then 5B again: events 5, none, 5. Reset mid-SETTLE: no event after release.
